// File: rtl/dm_access_unit_if.sv
// Request/acknowledge data-memory bus shared by the M-stage access unit
// (master) and the memory responder (slave).
interface dm_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dm_access_unit.sv
// M-stage data-access controller: turns each load/store into one req/ack bus
// transaction, stalls the pipeline meanwhile, flags misalignment, times out.
module dm_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        DMWrM,
  input  logic        DMRdM,
  input  logic [2:0]  DMOpM,
  input  logic [31:0] ALUM,
  input  logic [31:0] R2M,
  input  logic        GeneralFlush,
  dm_access_unit_if.master bus,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_req;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [3:0]       r_be;
  logic [31:0]      r_wdata;
  logic [2:0]       r_op;
  logic [1:0]       r_lo;
  logic [31:0]      r_ld_data;
  logic             r_bus_err;

  logic             w_is_half;
  logic             w_is_byte;
  logic             w_aligned;
  logic             w_access;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;

  // Aligns the addressed lane down to bit 0 and extends it as DMOpM selects.
  function automatic logic [31:0] fmt_load(input logic [31:0] rd,
                                           input logic [2:0]  op,
                                           input logic [1:0]  lo);
    logic signed [15:0] s_half;
    logic signed [7:0]  s_byte;
    s_half = lo[1] ? rd[31:16] : rd[15:0];
    s_byte = rd[{lo, 3'b000} +: 8];
    case (op)
      3'd1:    fmt_load = 32'(s_half);
      3'd2:    fmt_load = {16'h0000, s_half};
      3'd3:    fmt_load = 32'(s_byte);
      3'd4:    fmt_load = {24'h000000, s_byte};
      default: fmt_load = rd;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_comb begin
    w_is_half = (DMOpM == 3'd1) || (DMOpM == 3'd2);
    w_is_byte = (DMOpM == 3'd3) || (DMOpM == 3'd4);
    if (w_is_byte)      w_aligned = 1'b1;
    else if (w_is_half) w_aligned = ~ALUM[0];
    else                w_aligned = (ALUM[1:0] == 2'b00);
  end

  assign w_access = (DMWrM | DMRdM) & w_aligned & ~GeneralFlush;
  assign exc_adel = DMRdM & ~w_aligned;
  assign exc_ades = DMWrM & ~w_aligned;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = R2M;
    if (w_is_half) begin
      w_be    = ALUM[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{R2M[15:0]}};
    end else if (w_is_byte) begin
      w_be    = 4'b0001 << ALUM[1:0];
      w_wdata = {4{R2M[7:0]}};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bus_req <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_op      <= '0;
      r_lo      <= '0;
      r_ld_data <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_addr    <= {ALUM[31:2], 2'b00};
            r_be      <= w_be;
            r_wdata   <= w_wdata;
            r_we      <= DMWrM;
            r_op      <= DMOpM;
            r_lo      <= ALUM[1:0];
            r_cnt     <= '0;
            r_bus_req <= 1'b1;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          // An ack on the final allowed cycle still counts as a normal completion.
          if (bus.bus_ack) begin
            if (!r_we) r_ld_data <= fmt_load(bus.bus_rdata, r_op, r_lo);
            r_bus_req <= 1'b0;
            r_state   <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            if (!r_we) r_ld_data <= '0;
            r_bus_err <= 1'b1;
            r_bus_req <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: begin
          r_bus_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign stall         = ((r_state == S_IDLE) & w_access) | (r_state == S_REQ);
  assign ld_data       = r_ld_data;
  assign bus_err       = r_bus_err;
  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_be    = r_be;
  assign bus.bus_wdata = r_wdata;

endmodule

// File: tb/tb_dm_access_unit.sv
// Randomized self-checking bench for dm_access_unit against a behavioural
// model of the access rules (sizes, lanes, extension, latency, timeout).
module tb_dm_access_unit;
  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        DMWrM, DMRdM, GeneralFlush;
  logic [2:0]  DMOpM;
  logic [31:0] ALUM, R2M;
  logic        stall, exc_adel, exc_ades, bus_err;
  logic [31:0] ld_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_ld = 32'h0;

  dm_access_unit_if bif();

  dm_access_unit #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .DMWrM(DMWrM), .DMRdM(DMRdM),
    .DMOpM(DMOpM), .ALUM(ALUM), .R2M(R2M), .GeneralFlush(GeneralFlush),
    .bus(bif), .stall(stall), .ld_data(ld_data),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return 2;
    if (op == 3'd3 || op == 3'd4) return 1;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] op, input logic [31:0] a);
    int sz = acc_size(op);
    if (sz == 4) return 4'hF;
    if (sz == 2) return (a % 4 >= 2) ? 4'hC : 4'h3;
    return 4'(1 << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] d);
    int sz = acc_size(op);
    if (sz == 4) return d;
    if (sz == 2) return (d % 32'h10000) * 32'h0001_0001;
    return (d % 32'h100) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] rd);
    int sz = acc_size(op);
    logic [31:0] v;
    if (sz == 4) return rd;
    if (sz == 2) begin
      v = (rd >> ((a % 4) / 2 * 16)) % 32'h10000;
      if (op == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = (rd >> ((a % 4) * 8)) % 32'h100;
      if (op == 3'd3 && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end
    return v;
  endfunction

  task automatic idle_inputs();
    DMWrM = 1'b0; DMRdM = 1'b0; GeneralFlush = 1'b0;
    DMOpM = 3'd0; ALUM = 32'h0; R2M = 32'h0;
    bif.bus_ack = 1'b0; bif.bus_rdata = 32'h0;
  endtask

  // One M-stage access from the pipeline's point of view; waits = ack delay.
  task automatic access(input logic we, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int waits, input logic flush, input logic tmo);
    logic aligned, go, done;
    int stalls, reqc;
    @(negedge clock);
    DMWrM = we; DMRdM = ~we; DMOpM = op; ALUM = a; R2M = wd;
    GeneralFlush = flush; bif.bus_ack = 1'b0;
    #1;
    aligned = (a % acc_size(op)) == 0;
    go = aligned && !flush;
    check("exc_adel", exc_adel, !we && !aligned);
    check("exc_ades", exc_ades, we && !aligned);
    check("stall_c0", stall, go);
    if (!go) begin
      @(negedge clock);
      idle_inputs();
      for (int k = 0; k < 2; k++) begin
        #1 check("no_req", bif.bus_req, 1'b0);
        @(negedge clock);
      end
      return;
    end
    stalls = 1; reqc = 0; done = 1'b0;
    for (int c = 0; c < TO + 8; c++) begin
      @(negedge clock);
      bif.bus_ack = 1'b0;
      #1;
      if (!bif.bus_req) begin done = 1'b1; break; end
      reqc++;
      stalls += int'(stall);
      check("bus_addr", bif.bus_addr, {a[31:2], 2'b00});
      check("bus_be", 32'(bif.bus_be), 32'(m_be(op, a)));
      check("bus_we", bif.bus_we, we);
      if (we) check("bus_wdata", bif.bus_wdata, m_wdata(op, wd));
      if (!tmo && reqc == waits + 1) begin
        bif.bus_ack = 1'b1; bif.bus_rdata = rd;
      end else begin
        bif.bus_rdata = $urandom;
      end
    end
    if (!done) begin
      check("req_timeout_budget", 32'(reqc), 32'(TO + 8 - 1));
      idle_inputs();
      return;
    end
    if (!we) exp_ld = tmo ? 32'h0 : m_load(op, a, rd);
    check("req_cycles", 32'(reqc), tmo ? 32'(TO) : 32'(waits + 1));
    check("stall_cycles", 32'(stalls), tmo ? 32'(TO + 1) : 32'(waits + 2));
    check("stall_done", stall, 1'b0);
    check("bus_err_done", bus_err, tmo);
    check("ld_data", ld_data, exp_ld);
    // A stray ack outside REQ must not disturb anything.
    bif.bus_ack = 1'($urandom % 2); bif.bus_rdata = $urandom;
    @(negedge clock);
    idle_inputs();
    #1;
    check("idle_req", bif.bus_req, 1'b0);
    check("idle_err", bus_err, 1'b0);
    check("idle_ld", ld_data, exp_ld);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic        tmo;
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_req", bif.bus_req, 1'b0);
    check("rst_addr", bif.bus_addr, 32'h0);
    check("rst_be", 32'(bif.bus_be), 32'h0);
    check("rst_wdata", bif.bus_wdata, 32'h0);
    check("rst_we", bif.bus_we, 1'b0);
    check("rst_ld", ld_data, 32'h0);
    check("rst_err", bus_err, 1'b0);
    check("rst_stall", stall, 1'b0);
    reset = 1'b1;

    access(1'b0, 3'd0, 32'h0000_1004, 32'h0, 32'h8765_4321, 0, 1'b0, 1'b0);
    check("tp_word_ld", ld_data, 32'h8765_4321);
    access(1'b0, 3'd3, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0, 1'b0, 1'b0);
    check("tp_sbyte_ld", ld_data, 32'hFFFF_FF80);
    access(1'b0, 3'd4, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 1, 1'b0, 1'b0);
    check("tp_ubyte_ld", ld_data, 32'h0000_0080);
    access(1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 3, 1'b0, 1'b0);
    check("tp_store_keeps_ld", ld_data, 32'h0000_0080);
    access(1'b0, 3'd0, 32'h0000_0006, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    access(1'b1, 3'd2, 32'h0000_2003, 32'h5555_AAAA, 32'h0, 0, 1'b0, 1'b0);
    access(1'b0, 3'd2, 32'h0000_3002, 32'h0, 32'hC001_1234, 0, 1'b0, 1'b0);
    check("tp_uhalf_ld", ld_data, 32'h0000_C001);
    access(1'b0, 3'd0, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 1'b1);
    check("tp_timeout_ld", ld_data, 32'h0);
    access(1'b0, 3'd0, 32'h0000_5000, 32'h0, 32'h1111_2222, 0, 1'b1, 1'b0);
    access(1'b0, 3'd1, 32'h0000_5002, 32'h0, 32'h8001_7FFF, TO - 1, 1'b0, 1'b0);
    check("tp_shalf_last_ack", ld_data, 32'hFFFF_8001);

    // Reset in the middle of REQ must drop the transaction at once.
    @(negedge clock);
    DMRdM = 1'b1; DMOpM = 3'd0; ALUM = 32'h0000_6008;
    repeat (3) @(negedge clock);
    #1 check("pre_rst_req", bif.bus_req, 1'b1);
    idle_inputs();
    reset = 1'b0;
    @(negedge clock);
    #1;
    check("mid_rst_req", bif.bus_req, 1'b0);
    check("mid_rst_stall", stall, 1'b0);
    check("mid_rst_addr", bif.bus_addr, 32'h0);
    check("mid_rst_be", 32'(bif.bus_be), 32'h0);
    check("mid_rst_ld", ld_data, 32'h0);
    exp_ld = 32'h0;
    reset = 1'b1;

    for (int t = 0; t < 80; t++) begin
      op  = 3'($urandom % 8);
      a   = $urandom;
      if ($urandom % 4 != 0) a[1:0] = 2'b00;
      tmo = ($urandom % 12) == 0;
      access(1'($urandom % 2), op, a, $urandom, $urandom,
             int'($urandom % 6), ($urandom % 10) == 0, tmo);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang expected completion");
    $fatal(1, "bench time limit");
  end
endmodule
